// File: rtl/scan_transfer_receiver.sv
// Receiver side of the scanner transfer protocol: it arbitrates between two scanners,
// grants one at a time and captures the granted scanner's burst into a shared FIFO.
module scan_transfer_receiver #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 10,
  parameter int DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       scan_1_transfer_me,
  input  logic                       scan_2_transfer_me,
  input  logic [DATA_W-1:0]          scan_1_data,
  input  logic                       scan_1_valid,
  input  logic [DATA_W-1:0]          scan_2_data,
  input  logic                       scan_2_valid,
  output logic                       grant_1,
  output logic                       grant_2,
  output logic                       xfer_done,
  output logic                       xfer_abort,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  // state   | meaning
  // IDLE    | no grant; arbitrate between pending requests
  // GRANT   | winner chosen; raise its grant
  // RECEIVE | capture granted scanner's words until BURST_LEN or request drop
  // DONE    | xfer_done high for this single cycle
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RECEIVE, S_DONE} state_t;

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WCW = $clog2(BURST_LEN + 1);

  state_t             r_state;
  logic               r_sel;       // 0: scanner 1 owns the transfer, 1: scanner 2
  logic               r_rr;        // preferred scanner on a tie
  logic               r_grant_1;
  logic               r_grant_2;
  logic               r_xfer_done;
  logic               r_xfer_abort;
  logic [WCW-1:0]     r_word_cnt;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic               r_rd_valid;
  logic [DATA_W-1:0]  r_rd_data;

  logic               w_pick;
  logic               w_req;
  logic               w_valid;
  logic [DATA_W-1:0]  w_data;
  logic               w_wr_req;
  logic               w_full;
  logic               w_empty;
  logic               w_rd_ok;
  logic               w_wr_ok;

  assign w_pick   = (scan_1_transfer_me && scan_2_transfer_me) ? r_rr : scan_2_transfer_me;
  assign w_req    = r_sel ? scan_2_transfer_me : scan_1_transfer_me;
  assign w_valid  = r_sel ? scan_2_valid       : scan_1_valid;
  assign w_data   = r_sel ? scan_2_data        : scan_1_data;

  // A word is only taken while the owner still requests; a drop in the same cycle aborts.
  assign w_wr_req = (r_state == S_RECEIVE) && w_req && w_valid;
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_rd_ok  = rd_en && !w_empty;
  assign w_wr_ok  = w_wr_req && (!w_full || w_rd_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_rr         <= 1'b0;
      r_grant_1    <= 1'b0;
      r_grant_2    <= 1'b0;
      r_xfer_done  <= 1'b0;
      r_xfer_abort <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_xfer_done  <= 1'b0;
      r_xfer_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (scan_1_transfer_me || scan_2_transfer_me) begin
            r_sel   <= w_pick;
            r_rr    <= ~w_pick;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_grant_1 <= ~r_sel;
          r_grant_2 <= r_sel;
          r_state   <= S_RECEIVE;
        end
        S_RECEIVE: begin
          if (!w_req) begin
            r_grant_1    <= 1'b0;
            r_grant_2    <= 1'b0;
            r_xfer_abort <= 1'b1;
            r_word_cnt   <= '0;
            r_state      <= S_IDLE;
          end else if (w_valid) begin
            if (r_word_cnt == WCW'(BURST_LEN - 1)) begin
              r_grant_1   <= 1'b0;
              r_grant_2   <= 1'b0;
              r_xfer_done <= 1'b1;
              r_word_cnt  <= '0;
              r_state     <= S_DONE;
            end else begin
              r_word_cnt <= r_word_cnt + WCW'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= w_data;
  end

  // On full with a concurrent pop the read sees the old slot before it is overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_wr_req && !w_wr_ok) r_overflow <= 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign grant_1    = r_grant_1;
  assign grant_2    = r_grant_2;
  assign xfer_done  = r_xfer_done;
  assign xfer_abort = r_xfer_abort;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_scan_transfer_receiver.sv
// Scoreboard bench for scan_transfer_receiver: words are queued as they are driven
// and compared against the FIFO output as it is drained.
module tb_scan_transfer_receiver;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 10;
  localparam int DEPTH     = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              scan_1_transfer_me = 1'b0;
  logic              scan_2_transfer_me = 1'b0;
  logic [DATA_W-1:0] scan_1_data = '0;
  logic              scan_1_valid = 1'b0;
  logic [DATA_W-1:0] scan_2_data = '0;
  logic              scan_2_valid = 1'b0;
  logic              grant_1, grant_2, xfer_done, xfer_abort;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int both_cnt = 0;
  logic [DATA_W-1:0] q[$];
  logic exp_ovf = 1'b0;

  scan_transfer_receiver #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .scan_1_transfer_me(scan_1_transfer_me), .scan_2_transfer_me(scan_2_transfer_me),
    .scan_1_data(scan_1_data), .scan_1_valid(scan_1_valid),
    .scan_2_data(scan_2_data), .scan_2_valid(scan_2_valid),
    .grant_1(grant_1), .grant_2(grant_2), .xfer_done(xfer_done), .xfer_abort(xfer_abort),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (xfer_done)  done_cnt++;
    if (xfer_abort) abort_cnt++;
    if (grant_1 && grant_2) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Request, wait for the expected grant, send n words, then finish or abort.
  task automatic do_xfer(input bit r1, input bit r2, input int exp_sel, input int n,
                         input logic [DATA_W-1:0] base, input bit noise, input bit rd_too,
                         output int lat);
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] exp_rd;
    scan_1_transfer_me = r1;
    scan_2_transfer_me = r2;
    lat = 0;
    while (!(grant_1 || grant_2) && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat >= 10) begin
      errors++;
      $display("FAIL grant_timeout: got none within %0d cycles, expected scanner %0d", lat, exp_sel);
      scan_1_transfer_me = 1'b0;
      scan_2_transfer_me = 1'b0;
      @(negedge clk);
      return;
    end
    checks++;
    if ({grant_1, grant_2} !== ((exp_sel == 1) ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL grant_winner: got g1=%0b g2=%0b expected scanner %0d", grant_1, grant_2, exp_sel);
    end
    for (int i = 0; i < n; i++) begin
      w = base + DATA_W'(i);
      if (exp_sel == 1) begin
        scan_1_valid = 1'b1; scan_1_data = w;
        scan_2_valid = noise; scan_2_data = 8'hEE;
      end else begin
        scan_2_valid = 1'b1; scan_2_data = w;
        scan_1_valid = noise; scan_1_data = 8'hEE;
      end
      if (rd_too) begin
        rd_en = 1'b1;
        exp_rd = q.pop_front();
        q.push_back(w);
      end else if (q.size() < DEPTH) begin
        q.push_back(w);
      end else begin
        exp_ovf = 1'b1;
      end
      @(negedge clk);
      if (rd_too) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp_rd) begin
          errors++;
          $display("FAIL push_pop_data: got v=%0b d=%0h expected v=1 d=%0h", rd_valid, rd_data, exp_rd);
        end
      end
    end
    rd_en = 1'b0;
    scan_1_valid = 1'b0;
    scan_2_valid = 1'b0;
    if (n == BURST_LEN) begin
      checks++;
      if (xfer_done !== 1'b1 || grant_1 !== 1'b0 || grant_2 !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: got done=%0b g1=%0b g2=%0b expected done=1 grants=0",
                 xfer_done, grant_1, grant_2);
      end
      scan_1_transfer_me = 1'b0;
      scan_2_transfer_me = 1'b0;
    end else begin
      scan_1_transfer_me = 1'b0;
      scan_2_transfer_me = 1'b0;
      @(negedge clk);
      checks++;
      if (xfer_abort !== 1'b1 || grant_1 !== 1'b0 || grant_2 !== 1'b0) begin
        errors++;
        $display("FAIL abort_pulse: got abort=%0b g1=%0b g2=%0b expected abort=1 grants=0",
                 xfer_abort, grant_1, grant_2);
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic drain_all();
    int n;
    logic [DATA_W-1:0] exp;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      exp = q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("FAIL pop_data[%0d]: got v=%0b d=%0h expected v=1 d=%0h", i, rd_valid, rd_data, exp);
      end
    end
    rd_en = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 0) begin
      errors++;
      $display("FAIL drained_count: got %0d expected 0", fifo_count);
    end
  endtask

  task automatic check_level(input string name, input int exp_cnt, input logic exp_o);
    checks++;
    if (fifo_count !== exp_cnt || overflow !== exp_o) begin
      errors++;
      $display("FAIL %s: got count=%0d ovf=%0b expected count=%0d ovf=%0b",
               name, fifo_count, overflow, exp_cnt, exp_o);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({grant_1, grant_2, xfer_done, xfer_abort, rd_valid, overflow, fifo_count, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got g1=%0b g2=%0b d=%0b a=%0b v=%0b o=%0b c=%0d rd=%0h expected all 0",
               grant_1, grant_2, xfer_done, xfer_abort, rd_valid, overflow, fifo_count, rd_data);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    int lat, d0;
    d0 = done_cnt;
    do_xfer(1, 0, 1, BURST_LEN, 8'h01, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL grant_latency: got %0d expected 2", lat);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL done_count: got %0d expected 1", done_cnt - d0);
    end
    check_level("burst_count", BURST_LEN, 1'b0);
    drain_all();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_read: got rd_valid=%0b expected 0", rd_valid);
    end
  endtask

  task automatic test_abort();
    int lat, d0, a0;
    d0 = done_cnt;
    a0 = abort_cnt;
    do_xfer(0, 1, 2, 4, 8'h20, 1'b0, 1'b0, lat);
    checks++;
    if (abort_cnt - a0 !== 1 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL abort_counts: got abort=%0d done=%0d expected abort=1 done=0",
               abort_cnt - a0, done_cnt - d0);
    end
    check_level("abort_count", 4, 1'b0);
    drain_all();
  endtask

  task automatic test_arbitration();
    int lat, b0;
    b0 = both_cnt;
    do_xfer(1, 1, 1, 2, 8'h40, 1'b1, 1'b0, lat);
    do_xfer(1, 1, 2, 2, 8'h48, 1'b1, 1'b0, lat);
    checks++;
    if (both_cnt - b0 !== 0) begin
      errors++;
      $display("FAIL grant_onehot: got %0d cycles with both grants expected 0", both_cnt - b0);
    end
    check_level("arb_count", 4, 1'b0);
    drain_all();
  endtask

  task automatic test_full_push_pop();
    int lat;
    do_xfer(1, 0, 1, BURST_LEN, 8'h10, 1'b0, 1'b0, lat);
    do_xfer(0, 1, 2, 6, 8'h30, 1'b0, 1'b0, lat);
    check_level("fill_16", DEPTH, 1'b0);
    do_xfer(1, 0, 1, 4, 8'h50, 1'b0, 1'b1, lat);
    check_level("full_push_pop", DEPTH, 1'b0);
    drain_all();
  endtask

  task automatic test_overflow();
    int lat;
    do_xfer(0, 1, 2, BURST_LEN, 8'h60, 1'b0, 1'b0, lat);
    do_xfer(1, 0, 1, BURST_LEN, 8'h80, 1'b0, 1'b0, lat);
    check_level("overflow_state", DEPTH, exp_ovf);
    drain_all();
    check_level("overflow_sticky", 0, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    int lat;
    scan_1_transfer_me = 1'b1;
    lat = 0;
    while (!grant_1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      scan_1_valid = 1'b1;
      scan_1_data = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({grant_1, grant_2, xfer_done, xfer_abort, rd_valid, overflow, fifo_count, rd_data} !== '0) begin
      errors++;
      $display("FAIL midburst_reset: got g1=%0b g2=%0b d=%0b a=%0b v=%0b o=%0b c=%0d expected all 0",
               grant_1, grant_2, xfer_done, xfer_abort, rd_valid, overflow, fifo_count);
    end
    q.delete();
    exp_ovf = 1'b0;
    scan_1_valid = 1'b0;
    scan_1_transfer_me = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_xfer(1, 1, 1, 3, 8'hC0, 1'b0, 1'b0, lat);
    check_level("post_reset_count", 3, 1'b0);
    drain_all();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_abort();
    test_arbitration();
    test_full_push_pop();
    test_overflow();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
